// File: rtl/pcie_pkg.sv
// Shared PCIe completer types: TLP codes, completion status and queued read descriptor.
package pcie_pkg;

  typedef enum logic [2:0] {
    TLP_MRd  = 3'd0,
    TLP_MWr  = 3'd1,
    TLP_Cpl  = 3'd2,
    TLP_CplD = 3'd3
  } tlp_type_e;

  localparam logic [2:0] CPL_SC = 3'd0;
  localparam logic [2:0] CPL_UR = 3'd1;

  // Descriptor fields are sized for the widest supported config; the completer truncates.
  localparam int RQ_IDX_W = 32;
  localparam int RQ_LEN_W = 16;

  typedef struct packed {
    logic [7:0]          tag;
    logic [RQ_IDX_W-1:0] idx;
    logic [RQ_LEN_W-1:0] len;
    logic                oor;
  } rd_req_t;

endpackage

// File: rtl/pcie_cpl_fifo.sv
// Synchronous FIFO with show-ahead output; holds queued read descriptors.
module pcie_cpl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
      else if (!do_push && do_pop) cnt <= cnt - (AW+1)'(1);
    end
  end

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rp];

endmodule

// File: rtl/pcie_mem_completer.sv
// PCIe memory completer model: MWr/MRd with a ready-wait handshake, queued reads,
// multi-DW completions with UR for out-of-range addresses and completion backpressure.
module pcie_mem_completer
  import pcie_pkg::*;
#(
  parameter int               ADDR_W     = 32,
  parameter int               DATA_W     = 32,
  parameter int               LEN_W      = 10,
  parameter int               MEM_AW     = 12,
  parameter int               RD_LAT     = 2,
  parameter int               READY_WAIT = 2,
  parameter int               OUTST      = 4,
  parameter logic [DATA_W-1:0] SCRAMBLE  = 32'hDEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  tlp_type_e                 req_type,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [LEN_W-1:0]          req_len,
  input  logic [7:0]                req_tag,
  input  logic [DATA_W-1:0]         req_data,
  output logic                      cpl_valid,
  input  logic                      cpl_ready,
  output logic [2:0]                cpl_status,
  output logic [7:0]                cpl_tag,
  output logic [DATA_W-1:0]         cpl_data,
  output logic                      cpl_last,
  output logic [$clog2(OUTST):0]    outst_cnt
);

  localparam int OC_W = $clog2(OUTST) + 1;
  localparam int WC_W = $clog2(READY_WAIT + 1) + 1;
  localparam int BC_W = LEN_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCEPT = 2'd2;

  logic [1:0]      st;
  logic [WC_W-1:0] wcnt;
  logic            credit;
  logic            xfer, acc_rd, acc_wr, req_oor;
  logic [MEM_AW-1:0] req_idx;
  rd_req_t         acc_req;

  // MWr is held off along with MRd when credits run out so writes never pass queued reads.
  assign credit  = outst_cnt < OC_W'(OUTST);
  assign xfer    = req_valid && req_ready;
  assign req_oor = |req_addr[ADDR_W-1:MEM_AW+2];
  assign req_idx = req_addr[MEM_AW+1:2];
  assign acc_rd  = xfer && (req_type == TLP_MRd);
  assign acc_wr  = xfer && (req_type == TLP_MWr) && !req_oor;

  always_comb begin
    acc_req     = '0;
    acc_req.tag = req_tag;
    acc_req.idx = RQ_IDX_W'(req_idx);
    acc_req.len = RQ_LEN_W'(req_len);
    acc_req.oor = req_oor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      wcnt      <= '0;
      req_ready <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (req_valid && credit) begin
            if (READY_WAIT == 0) begin
              st        <= ST_ACCEPT;
              req_ready <= 1'b1;
            end else begin
              st   <= ST_WAIT;
              wcnt <= WC_W'(READY_WAIT);
            end
          end
        end
        ST_WAIT: begin
          wcnt <= wcnt - WC_W'(1);
          if (wcnt == WC_W'(1)) begin
            st        <= ST_ACCEPT;
            req_ready <= 1'b1;
          end
        end
        ST_ACCEPT: begin
          st        <= ST_IDLE;
          req_ready <= 1'b0;
        end
        default: begin
          st        <= ST_IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  // Delay line: RD_LAT-1 registered stages plus the FIFO write and output load give RD_LAT.
  logic    push;
  rd_req_t push_req;

  if (RD_LAT == 1) begin : g_nodly
    assign push     = acc_rd;
    assign push_req = acc_req;
  end else begin : g_dly
    logic [RD_LAT-1:1] vld_pipe;
    rd_req_t           req_pipe [RD_LAT-1:1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_pipe <= '0;
        for (int k = 1; k < RD_LAT; k++) req_pipe[k] <= '0;
      end else begin
        vld_pipe[1] <= acc_rd;
        req_pipe[1] <= acc_req;
        for (int k = 2; k < RD_LAT; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          req_pipe[k] <= req_pipe[k-1];
        end
      end
    end

    assign push     = vld_pipe[RD_LAT-1];
    assign push_req = req_pipe[RD_LAT-1];
  end

  rd_req_t          head;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [OC_W-1:0]  fifo_cnt;

  pcie_cpl_fifo #(.W($bits(rd_req_t)), .DEPTH(OUTST)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_req),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  logic [DATA_W-1:0] mem [2**MEM_AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= '0;
    end else if (acc_wr) begin
      mem[req_idx] <= req_data;
    end
  end

  logic              busy, slot_free, cpl_done;
  logic [BC_W-1:0]   rem, hbeats;
  logic [MEM_AW-1:0] nxt_idx, hidx;
  logic [LEN_W-1:0]  hlen;

  assign slot_free = !cpl_valid || cpl_ready;
  assign fifo_pop  = slot_free && !busy && !fifo_empty;
  assign cpl_done  = cpl_valid && cpl_ready && cpl_last;
  assign hidx      = head.idx[MEM_AW-1:0];
  assign hlen      = head.len[LEN_W-1:0];
  assign hbeats    = (hlen == '0) ? (BC_W'(1) << LEN_W) : BC_W'(hlen);

  // The output register is the only beat buffer; memory is sampled as each beat loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpl_valid  <= 1'b0;
      cpl_status <= CPL_SC;
      cpl_tag    <= '0;
      cpl_data   <= '0;
      cpl_last   <= 1'b0;
      busy       <= 1'b0;
      rem        <= '0;
      nxt_idx    <= '0;
    end else if (slot_free) begin
      if (busy) begin
        cpl_valid  <= 1'b1;
        cpl_status <= CPL_SC;
        cpl_data   <= mem[nxt_idx] ^ SCRAMBLE;
        cpl_last   <= (rem == BC_W'(1));
        busy       <= (rem != BC_W'(1));
        rem        <= rem - BC_W'(1);
        nxt_idx    <= nxt_idx + MEM_AW'(1);
      end else if (!fifo_empty) begin
        cpl_valid <= 1'b1;
        cpl_tag   <= head.tag;
        if (head.oor) begin
          cpl_status <= CPL_UR;
          cpl_data   <= '0;
          cpl_last   <= 1'b1;
          busy       <= 1'b0;
        end else begin
          cpl_status <= CPL_SC;
          cpl_data   <= mem[hidx] ^ SCRAMBLE;
          cpl_last   <= (hbeats == BC_W'(1));
          busy       <= (hbeats != BC_W'(1));
          rem        <= hbeats - BC_W'(1);
          nxt_idx    <= hidx + MEM_AW'(1);
        end
      end else begin
        cpl_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     outst_cnt <= '0;
    else if (acc_rd && !cpl_done) outst_cnt <= outst_cnt + OC_W'(1);
    else if (!acc_rd && cpl_done) outst_cnt <= outst_cnt - OC_W'(1);
  end

  logic misc_unused;
  assign misc_unused = ^{fifo_cnt, fifo_full, head, req_addr[1:0]};

endmodule

// File: tb/tb_pcie_mem_completer.sv
// Directed bench for pcie_mem_completer with default parameters.
module tb_pcie_mem_completer;
  import pcie_pkg::*;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  tlp_type_e   req_type;
  logic [31:0] req_addr;
  logic [9:0]  req_len;
  logic [7:0]  req_tag;
  logic [31:0] req_data;
  logic        cpl_valid, cpl_ready;
  logic [2:0]  cpl_status;
  logic [7:0]  cpl_tag;
  logic [31:0] cpl_data;
  logic        cpl_last;
  logic [2:0]  outst_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcie_mem_completer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_tag    (req_tag),
    .req_data   (req_data),
    .cpl_valid  (cpl_valid),
    .cpl_ready  (cpl_ready),
    .cpl_status (cpl_status),
    .cpl_tag    (cpl_tag),
    .cpl_data   (cpl_data),
    .cpl_last   (cpl_last),
    .outst_cnt  (outst_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of sampled cycles req_ready was low, including the detect cycle.
  task automatic send(input tlp_type_e t, input logic [31:0] a, input logic [9:0] l,
                      input logic [7:0] tg, input logic [31:0] d, output int lows);
    int n;
    lows = 0;
    n = 0;
    req_type = t; req_addr = a; req_len = l; req_tag = tg; req_data = d;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      lows++;
      step();
      n++;
    end
    chk("send_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic get_beat(output logic [31:0] d, output logic [7:0] tg,
                          output logic [2:0] st, output logic lst);
    int n;
    n = 0;
    while (!cpl_valid && n < 200) begin
      step();
      n++;
    end
    chk("beat_valid", {31'd0, cpl_valid}, 32'd1);
    d = cpl_data; tg = cpl_tag; st = cpl_status; lst = cpl_last;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
  endtask

  initial begin
    int          lows, nb, n, acc_at;
    logic        acc, hi, prev_stall;
    logic [31:0] d, pd;
    logic [7:0]  tg, pt;
    logic [2:0]  st;
    logic        lst, pl;
    logic [31:0] bd [16];
    logic [7:0]  bt [16];
    logic        bl [16];

    rst = 1'b1; req_valid = 1'b0; req_type = TLP_MRd; req_addr = '0; req_len = '0;
    req_tag = '0; req_data = '0; cpl_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_cpl_valid", {31'd0, cpl_valid}, 32'd0);
    chk("rst_cpl_status", {29'd0, cpl_status}, 32'd0);
    chk("rst_cpl_tag", {24'd0, cpl_tag}, 32'd0);
    chk("rst_cpl_data", cpl_data, 32'd0);
    chk("rst_cpl_last", {31'd0, cpl_last}, 32'd0);
    chk("rst_outst", {29'd0, outst_cnt}, 32'd0);
    rst = 1'b0;
    step();

    // Write then read one word; ready-wait window and first-beat latency.
    send(TLP_MWr, 32'h10, 10'd1, 8'h00, 32'h1234_5678, lows);
    chk("mwr_ready_wait", lows - 1, 32'd2);
    send(TLP_MRd, 32'h10, 10'd1, 8'h05, 32'd0, lows);
    chk("mrd_ready_wait", lows - 1, 32'd2);
    chk("outst_inc", {29'd0, outst_cnt}, 32'd1);
    chk("lat_t0", {31'd0, cpl_valid}, 32'd0);
    step();
    chk("lat_t1", {31'd0, cpl_valid}, 32'd0);
    step();
    chk("lat_t2", {31'd0, cpl_valid}, 32'd1);
    chk("b1_data", cpl_data, 32'h1234_5678 ^ KEY);
    chk("b1_tag", {24'd0, cpl_tag}, 32'h05);
    chk("b1_status", {29'd0, cpl_status}, {29'd0, CPL_SC});
    chk("b1_last", {31'd0, cpl_last}, 32'd1);
    step();
    chk("b1_consumed", {31'd0, cpl_valid}, 32'd0);
    chk("outst_dec", {29'd0, outst_cnt}, 32'd0);

    // Read that wraps past the top of memory after reset.
    do_reset();
    send(TLP_MRd, 32'h3FF8, 10'd4, 8'h11, 32'd0, lows);
    for (int i = 0; i < 4; i++) begin
      get_beat(d, tg, st, lst);
      chk("wrap_data", d, KEY);
      chk("wrap_tag", {24'd0, tg}, 32'h11);
      chk("wrap_last", {31'd0, lst}, (i == 3) ? 32'd1 : 32'd0);
    end

    // Out-of-range read and write.
    send(TLP_MRd, 32'h0001_0000, 10'd1, 8'h22, 32'd0, lows);
    get_beat(d, tg, st, lst);
    chk("ur_status", {29'd0, st}, {29'd0, CPL_UR});
    chk("ur_data", d, 32'd0);
    chk("ur_last", {31'd0, lst}, 32'd1);
    chk("ur_tag", {24'd0, tg}, 32'h22);
    send(TLP_MWr, 32'h0001_0000, 10'd1, 8'h00, 32'hAAAA_5555, lows);
    send(TLP_MRd, 32'h0, 10'd1, 8'h23, 32'd0, lows);
    get_beat(d, tg, st, lst);
    chk("ur_wr_dropped", d, KEY);

    // Distinct data on both sides of the wrap point.
    send(TLP_MWr, 32'h0, 10'd1, 8'h00, 32'h1, lows);
    send(TLP_MRd, 32'h3FFC, 10'd2, 8'h24, 32'd0, lows);
    get_beat(d, tg, st, lst);
    chk("wrap2_b0", d, KEY);
    get_beat(d, tg, st, lst);
    chk("wrap2_b1", d, 32'h1 ^ KEY);
    chk("wrap2_last", {31'd0, lst}, 32'd1);

    // Credit limit: four reads fill the queue, the fifth waits for a credit.
    for (int j = 0; j < 10; j++)
      send(TLP_MWr, 32'h100 + 32'(4 * j), 10'd1, 8'h00, 32'(j + 1), lows);
    cpl_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      send(TLP_MRd, 32'h100 + 32'(8 * k), 10'd2, 8'(8'h30 + k), 32'd0, lows);
    chk("credit_full", {29'd0, outst_cnt}, 32'd4);
    req_type = TLP_MRd; req_addr = 32'h120; req_len = 10'd2; req_tag = 8'h34;
    req_valid = 1'b1;
    hi = 1'b0;
    for (int c = 0; c < 20; c++) begin
      hi = hi | req_ready;
      step();
    end
    chk("credit_block", {31'd0, hi}, 32'd0);
    chk("credit_hold", {29'd0, outst_cnt}, 32'd4);
    chk("stall_tag", {24'd0, cpl_tag}, 32'h30);
    cpl_ready = 1'b1;
    nb = 0; n = 0; acc = 1'b0; acc_at = -1;
    while (nb < 10 && n < 300) begin
      hi = req_valid && req_ready;
      if (cpl_valid) begin
        bd[nb] = cpl_data; bt[nb] = cpl_tag; bl[nb] = cpl_last;
        nb++;
      end
      step();
      n++;
      if (hi) begin
        req_valid = 1'b0;
        acc = 1'b1;
        acc_at = nb;
      end
    end
    chk("q_beats", nb, 32'd10);
    chk("q_fifth_acc", {31'd0, acc}, 32'd1);
    chk("q_fifth_after_credit", {31'd0, acc_at >= 2}, 32'd1);
    for (int i = 0; i < nb; i++) begin
      chk("q_tag", {24'd0, bt[i]}, 32'h30 + 32'(i / 2));
      chk("q_data", bd[i], 32'(i + 1) ^ KEY);
      chk("q_last", {31'd0, bl[i]}, 32'(i % 2));
    end
    repeat (3) step();
    chk("q_outst_zero", {29'd0, outst_cnt}, 32'd0);

    // Toggling backpressure during a three-beat read.
    cpl_ready = 1'b0;
    send(TLP_MRd, 32'h100, 10'd3, 8'h40, 32'd0, lows);
    nb = 0; n = 0; prev_stall = 1'b0; pd = '0; pt = '0; pl = 1'b0;
    while (nb < 3 && n < 100) begin
      cpl_ready = ~cpl_ready;
      if (prev_stall) begin
        chk("bp_valid", {31'd0, cpl_valid}, 32'd1);
        chk("bp_data", cpl_data, pd);
        chk("bp_tag", {24'd0, cpl_tag}, {24'd0, pt});
        chk("bp_last", {31'd0, cpl_last}, {31'd0, pl});
      end
      if (cpl_valid && cpl_ready) begin
        bd[nb] = cpl_data; bt[nb] = cpl_tag; bl[nb] = cpl_last;
        nb++;
      end
      prev_stall = cpl_valid && !cpl_ready;
      pd = cpl_data; pt = cpl_tag; pl = cpl_last;
      step();
      n++;
    end
    chk("bp_beats", nb, 32'd3);
    for (int i = 0; i < nb; i++) begin
      chk("bp_b_data", bd[i], 32'(i + 1) ^ KEY);
      chk("bp_b_tag", {24'd0, bt[i]}, 32'h40);
      chk("bp_b_last", {31'd0, bl[i]}, (i == 2) ? 32'd1 : 32'd0);
    end
    cpl_ready = 1'b1;
    hi = 1'b0;
    for (int c = 0; c < 5; c++) begin
      hi = hi | cpl_valid;
      step();
    end
    chk("bp_no_extra", {31'd0, hi}, 32'd0);

    // Reset with a stalled beat and reads still queued.
    cpl_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      send(TLP_MRd, 32'h100, 10'd2, 8'(8'h50 + k), 32'd0, lows);
    n = 0;
    while (!cpl_valid && n < 50) begin
      step();
      n++;
    end
    chk("mr_stalled", {31'd0, cpl_valid}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("mr_cpl_valid", {31'd0, cpl_valid}, 32'd0);
    chk("mr_cpl_data", cpl_data, 32'd0);
    chk("mr_cpl_tag", {24'd0, cpl_tag}, 32'd0);
    chk("mr_cpl_last", {31'd0, cpl_last}, 32'd0);
    chk("mr_cpl_status", {29'd0, cpl_status}, 32'd0);
    chk("mr_outst", {29'd0, outst_cnt}, 32'd0);
    chk("mr_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cpl_ready = 1'b1;
    hi = 1'b0;
    for (int c = 0; c < 20; c++) begin
      hi = hi | cpl_valid;
      step();
    end
    chk("mr_no_cpl", {31'd0, hi}, 32'd0);
    chk("mr_outst_after", {29'd0, outst_cnt}, 32'd0);
    send(TLP_MRd, 32'h100, 10'd1, 8'h60, 32'd0, lows);
    get_beat(d, tg, st, lst);
    chk("mr_mem_cleared", d, KEY);
    chk("mr_tag", {24'd0, tg}, 32'h60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
